m68k_dram_arbiter: RTL and testbench

Shares the single SDRAM controller between the 68000 bus (CPU) and the 800x480 video frame-buffer fetch engine (VID).
- Picks one requester, holds its grant for exactly one controller access, and issues a start pulse to the controller.
- Waits for the controller's done pulse, with a watchdog, before re-arbitrating.
- Sits between the CPU address decode / video DMA and the SDRAM controller's request port.

---
 rtl/m68k_dram_arbiter.sv | 142 ++++++++++++++
 tb/tb_m68k_dram_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/m68k_dram_arbiter.sv
// Arbitrates the single SDRAM controller between the 68000 bus (CPU) and video fetch (VID).
// Optional grant/timeout statistics counters are enabled with `define ARB_STATS_EN.
module m68k_dram_arbiter #(
    parameter int unsigned MAX_CPU_BURST = 4,
    parameter int unsigned VID_BURST     = 8,
    parameter int unsigned DONE_TIMEOUT  = 64
) (
    input  logic        i_Clock,
    input  logic        i_Reset_H,
    input  logic        i_Cpu_Req_H,
    input  logic        i_Vid_Req_H,
    input  logic        i_Vid_Urgent_H,
    output logic        o_Cpu_Grant_H,
    output logic        o_Vid_Grant_H,
    output logic        o_Ctl_Start_H,
    input  logic        i_Ctl_Busy_H,
    input  logic        i_Ctl_Done_H,
    output logic [1:0]  o_Owner,
    output logic        o_Timeout_H
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] o_Cpu_Grants,
    output logic [31:0] o_Vid_Grants,
    output logic [15:0] o_Timeouts
`endif
);

    localparam int unsigned CW  = $clog2(MAX_CPU_BURST + 1);
    localparam int unsigned VW  = $clog2(VID_BURST + 1);
    localparam int unsigned WDW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CpuMax = CW'(MAX_CPU_BURST);
    localparam logic [VW-1:0]  VidMax = VW'(VID_BURST);
    localparam logic [WDW-1:0] WdLast = WDW'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StRelease} state_e;

    state_e         r_state, w_state_next;
    logic           r_vid_sel;
    logic [CW-1:0]  r_cpu_streak;
    logic [VW-1:0]  r_vid_streak;
    logic [WDW-1:0] r_wd;
    logic           w_pick_cpu, w_pick_vid, w_wd_expire, w_grant_on;

    // Urgent video first, then CPU up to its burst limit, then video; a full VID streak
    // hands the next non-urgent slot to a waiting CPU.
    always_comb begin
        w_pick_cpu = 1'b0;
        w_pick_vid = 1'b0;
        if (i_Vid_Req_H && i_Vid_Urgent_H) begin
            w_pick_vid = 1'b1;
        end else if (i_Cpu_Req_H && (!i_Vid_Req_H || r_cpu_streak < CpuMax)) begin
            w_pick_cpu = 1'b1;
        end else if (i_Cpu_Req_H && i_Vid_Req_H && r_vid_streak == VidMax) begin
            w_pick_cpu = 1'b1;
        end else if (i_Vid_Req_H) begin
            w_pick_vid = 1'b1;
        end
    end

    assign w_wd_expire = (r_wd == WdLast);

    always_ff @(posedge i_Clock) begin
        if (i_Reset_H) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (w_pick_cpu || w_pick_vid) w_state_next = StStart;
            StStart:   if (!i_Ctl_Busy_H) w_state_next = StWait;
            StWait:    if (i_Ctl_Done_H || w_wd_expire) w_state_next = StRelease;
            StRelease: w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_grant_on    = (r_state == StStart) || (r_state == StWait);
        o_Cpu_Grant_H = w_grant_on && !r_vid_sel;
        o_Vid_Grant_H = w_grant_on && r_vid_sel;
        o_Owner       = w_grant_on ? (r_vid_sel ? 2'b10 : 2'b01) : 2'b00;
        o_Ctl_Start_H = (r_state == StStart) && !i_Ctl_Busy_H;
        o_Timeout_H   = (r_state == StWait) && w_wd_expire && !i_Ctl_Done_H;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset_H) begin
            r_vid_sel    <= 1'b0;
            r_cpu_streak <= '0;
            r_vid_streak <= '0;
            r_wd         <= '0;
        end else begin
            if (r_state == StIdle && (w_pick_cpu || w_pick_vid)) begin
                r_vid_sel <= w_pick_vid;
                if (w_pick_vid) begin
                    r_cpu_streak <= '0;
                    if (r_vid_streak != VidMax) r_vid_streak <= r_vid_streak + 1'b1;
                end else begin
                    r_vid_streak <= '0;
                    if (r_cpu_streak != CpuMax) r_cpu_streak <= r_cpu_streak + 1'b1;
                end
            end
            if (r_state == StWait) begin
                r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] r_cpu_grants, r_vid_grants;
    logic [15:0] r_timeouts;

    always_ff @(posedge i_Clock) begin
        if (i_Reset_H) begin
            r_cpu_grants <= '0;
            r_vid_grants <= '0;
            r_timeouts   <= '0;
        end else begin
            if (r_state == StIdle && w_pick_cpu && r_cpu_grants != '1) begin
                r_cpu_grants <= r_cpu_grants + 1'b1;
            end
            if (r_state == StIdle && w_pick_vid && r_vid_grants != '1) begin
                r_vid_grants <= r_vid_grants + 1'b1;
            end
            if (o_Timeout_H && r_timeouts != '1) begin
                r_timeouts <= r_timeouts + 1'b1;
            end
        end
    end

    assign o_Cpu_Grants = r_cpu_grants;
    assign o_Vid_Grants = r_vid_grants;
    assign o_Timeouts   = r_timeouts;
`endif

endmodule

// File: tb/tb_m68k_dram_arbiter.sv
// Scoreboard bench: the driver predicts owner and event cycles from a grant-history model,
// an independent monitor pops and compares whenever the DUT shows a grant/start/timeout/release.
module tb_m68k_dram_arbiter;

    localparam int MaxCpu = 4;
    localparam int VidBurst = 8;
    localparam int Tmo = 64;

    localparam int EvGrant = 0;
    localparam int EvStart = 1;
    localparam int EvTimeout = 2;
    localparam int EvRel = 3;

    typedef struct {
        int         kind;
        logic [1:0] own;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_req = 1'b0, vid_req = 1'b0, urg = 1'b0, busy = 1'b0, done = 1'b0;
    logic cpu_gnt, vid_gnt, start, tmo;
    logic [1:0] owner;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    ev_t exp_q[$];
    logic [1:0] hist[$];
    logic [1:0] prev_owner = 2'b00;

    m68k_dram_arbiter #(
        .MAX_CPU_BURST(MaxCpu),
        .VID_BURST    (VidBurst),
        .DONE_TIMEOUT (Tmo)
    ) dut (
        .i_Clock       (clk),
        .i_Reset_H     (rst),
        .i_Cpu_Req_H   (cpu_req),
        .i_Vid_Req_H   (vid_req),
        .i_Vid_Urgent_H(urg),
        .o_Cpu_Grant_H (cpu_gnt),
        .o_Vid_Grant_H (vid_gnt),
        .o_Ctl_Start_H (start),
        .i_Ctl_Busy_H  (busy),
        .i_Ctl_Done_H  (done),
        .o_Owner       (owner),
        .o_Timeout_H   (tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, req, cyc);
    endtask

    task automatic push(input int kind, input logic [1:0] own, input int at);
        ev_t e;
        e.kind = kind;
        e.own  = own;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_cycle", cyc, e.cyc);
            if (kind == EvGrant) check("grant_owner", int'({vid_gnt, cpu_gnt}), int'(e.own));
            if (kind == EvRel) check("release_grants", int'({vid_gnt, cpu_gnt}), 0);
        end
    endtask

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (owner == 2'b11) check("owner_legal", int'(owner), 0);
        if (owner != 2'b00 && prev_owner == 2'b00) got_ev(EvGrant);
        if (start) got_ev(EvStart);
        if (tmo) got_ev(EvTimeout);
        if (owner == 2'b00 && prev_owner != 2'b00) got_ev(EvRel);
        prev_owner = owner;
    end

    // Reference: count trailing consecutive grants of each owner in the history.
    function automatic logic [1:0] model_pick(input bit c, input bit v, input bit u);
        int cr = 0;
        int vr = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != 2'b01) break;
            cr++;
        end
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != 2'b10) break;
            vr++;
        end
        if (v && u) return 2'b10;
        if (c && (!v || cr < MaxCpu)) return 2'b01;
        if (c && v && vr >= VidBurst) return 2'b01;
        if (v) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access from IDLE: b busy cycles in START, done on WAIT cycle d (0 = never).
    task automatic txn(input bit c, input bit v, input bit u, input int b, input int d,
                       input bit spur, input bit rst_mid);
        int k0, s;
        logic [1:0] own;
        k0  = cyc;
        own = model_pick(c, v, u);
        hist.push_back(own);
        s = k0 + 1 + b;
        push(EvGrant, own, k0 + 1);
        push(EvStart, 2'b00, s);
        if (rst_mid) push(EvRel, 2'b00, s + 4);
        else if (d == 0) begin
            push(EvTimeout, 2'b00, s + Tmo);
            push(EvRel, 2'b00, s + Tmo + 1);
        end else push(EvRel, 2'b00, s + d + 1);
        cpu_req = c;
        vid_req = v;
        urg     = u;
        busy    = (b > 0);
        done    = spur;
        step();
        cpu_req = 1'b0;
        vid_req = 1'b0;
        urg     = 1'b0;
        done    = 1'b0;
        if (b > 0) begin
            repeat (b) step();
            busy = 1'b0;
        end
        if (rst_mid) begin
            repeat (3) step();
            rst = 1'b1;
            step();
            rst  = 1'b0;
            check("rst_mid_outputs", int'({cpu_gnt, vid_gnt, start, tmo, owner}), 0);
            done = 1'b1;
            step();
            done = 1'b0;
            hist.delete();
        end else if (d == 0) begin
            repeat (Tmo + 1) step();
            step();
        end else begin
            repeat (d) step();
            done = 1'b1;
            step();
            done = 1'b0;
            step();
        end
    endtask

    initial begin
        bit c, v;
        int d;
        repeat (3) step();
        check("reset_outputs", int'({cpu_gnt, vid_gnt, start, tmo, owner}), 0);
        rst = 1'b0;
        step();
        check("idle_outputs", int'({cpu_gnt, vid_gnt, start, tmo, owner}), 0);

        txn(1, 0, 0, 0, 5, 0, 0);
        for (int i = 0; i < 10; i++) txn(1, 1, 0, 0, 3, 0, 0);
        for (int i = 0; i < 10; i++) txn(1, 1, 1, 0, 3, 0, 0);
        txn(1, 1, 0, 0, 3, 0, 0);
        txn(1, 0, 0, 10, 3, 0, 0);
        txn(0, 1, 0, 0, 0, 0, 0);
        txn(0, 1, 0, 0, Tmo, 0, 0);
        txn(1, 0, 0, 0, 2, 1, 0);
        for (int i = 0; i < 4; i++) txn(1, 0, 0, 0, 2, 0, 0);
        txn(1, 0, 0, 0, 0, 0, 1);
        txn(1, 1, 0, 0, 2, 0, 0);

        for (int i = 0; i < 40; i++) begin
            c = bit'($urandom_range(0, 1));
            v = bit'($urandom_range(0, 1));
            if (!c && !v) c = 1'b1;
            case ($urandom_range(0, 9))
                0:       d = 0;
                1:       d = Tmo;
                default: d = $urandom_range(1, 8);
            endcase
            txn(c, v, v && ($urandom_range(0, 3) == 0), $urandom_range(0, 3), d,
                bit'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) step();
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
